// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch squash,
// memory-wait freeze, plus saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W      = 4,
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // state    | meaning
  // RUN      | normal flow; branches flush, load-use hazards start bubbles
  // LU_STALL | inserting remaining load-use bubbles (lu_cnt left)
  // MEM_WAIT | whole pipe frozen on a data access; saved_state resumes on exit
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LU_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  localparam logic [2:0] LU_INIT = 3'(LU_STALL_CYCLES - 1);

  logic [2:0] lu_cnt, lu_nx;
  logic [1:0] saved_state, saved_nx, state_nx, eff_state;
  logic       hz, mw, flush_evt;

  assign hz = id_valid & ex_mem_read & (ex_rd != '0) &
              ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign mw = mem_req & ~mem_ready;

  // On a memory-wait exit the controller behaves as the state it was frozen in
  assign eff_state = (state == MEM_WAIT) ? saved_state : state;

  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_nx   = state;
    lu_nx      = lu_cnt;
    saved_nx   = saved_state;
    flush_evt  = 1'b0;

    if (reset) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mw) begin
      state_nx = MEM_WAIT;
      if (state != MEM_WAIT) saved_nx = state;
    end else begin
      case (eff_state)
        LU_STALL: begin
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          idex_flush = 1'b1;
          lu_nx      = (lu_cnt != 3'd0) ? lu_cnt - 3'd1 : 3'd0;
          state_nx   = (lu_cnt <= 3'd1) ? RUN : LU_STALL;
        end
        default: begin
          state_nx = RUN;
          if (ex_branch_taken) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_evt  = 1'b1;
          end else if (hz) begin
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            idex_flush = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
              lu_nx    = LU_INIT;
              state_nx = LU_STALL;
            end
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      lu_cnt      <= 3'd0;
      saved_state <= RUN;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state       <= state_nx;
      lu_cnt      <= lu_nx;
      saved_state <= saved_nx;
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for single-cycle decode,
// hand sequences for stalls, memory waits, saturation and reset abort.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic [3:0] id_rs1, id_rs2, ex_rd;

  logic       pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush;
  logic [1:0] state;
  logic [15:0] stall_cnt, flush_cnt;

  logic       pc_en3, ifid_en3, idex_en3, exmem_en3, ifid_flush3, idex_flush3;
  logic [1:0] state3;
  logic [3:0] stall_cnt3, flush_cnt3;

  logic [5:0] o1, o3;
  assign o1 = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush};
  assign o3 = {pc_en3, ifid_en3, idex_en3, exmem_en3, ifid_flush3, idex_flush3};

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.REG_ADDR_W(4), .LU_STALL_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en3), .ifid_en(ifid_en3), .idex_en(idex_en3), .exmem_en(exmem_en3),
    .ifid_flush(ifid_flush3), .idex_flush(idex_flush3), .state(state3),
    .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
  );

  // Expected outputs packed as {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}
  typedef struct {
    string      name;
    logic       iv;
    logic [3:0] rs1, rs2;
    logic       u1, u2;
    logic [3:0] rd;
    logic       mr, br, mq, my;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic drive_hz();
    idle();
    id_valid = 1; id_rs1 = 4'd5; id_use_rs1 = 1; ex_rd = 4'd5; ex_mem_read = 1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    int zeros;
    vecs[0]  = '{"idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111100};
    vecs[1]  = '{"hz_rs1",       1, 5, 0, 1, 0, 5, 1, 0, 0, 0, 6'b001101};
    vecs[2]  = '{"rd0_no_hz",    1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 6'b111100};
    vecs[3]  = '{"use1_off",     1, 5, 0, 0, 0, 5, 1, 0, 0, 0, 6'b111100};
    vecs[4]  = '{"hz_rs2",       1, 3, 7, 0, 1, 7, 1, 0, 0, 0, 6'b001101};
    vecs[5]  = '{"rs2_mismatch", 1, 7, 6, 0, 1, 7, 1, 0, 0, 0, 6'b111100};
    vecs[6]  = '{"not_load",     1, 5, 0, 1, 0, 5, 0, 0, 0, 0, 6'b111100};
    vecs[7]  = '{"id_invalid",   0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 6'b111100};
    vecs[8]  = '{"branch",       0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b111111};
    vecs[9]  = '{"branch_hz",    1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 6'b111111};
    vecs[10] = '{"mem_wait",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000000};
    vecs[11] = '{"mem_ready",    0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b111100};

    idle();
    reset = 1;
    @(negedge clk);
    chk("reset_outs", 32'(o1), 32'(6'b000011));
    tick();
    reset = 0;
    chk("reset_state", 32'(state), 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_flush_cnt", 32'(flush_cnt), 0);

    for (int i = 0; i < 12; i++) begin
      do_reset();
      id_valid = vecs[i].iv; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_use_rs1 = vecs[i].u1; id_use_rs2 = vecs[i].u2; ex_rd = vecs[i].rd;
      ex_mem_read = vecs[i].mr; ex_branch_taken = vecs[i].br;
      mem_req = vecs[i].mq; mem_ready = vecs[i].my;
      @(negedge clk);
      chk(vecs[i].name, 32'(o1), 32'(vecs[i].exp));
      tick();
    end

    // Load-use with one bubble
    do_reset();
    drive_hz();
    @(negedge clk);
    chk("lu1_stall_outs", 32'(o1), 32'(6'b001101));
    tick();
    idle();
    @(negedge clk);
    chk("lu1_resume_outs", 32'(o1), 32'(6'b111100));
    chk("lu1_state", 32'(state), 0);
    tick();
    chk("lu1_stall_cnt", 32'(stall_cnt), 1);

    // Branch coincident with hazard
    do_reset();
    drive_hz();
    ex_branch_taken = 1;
    @(negedge clk);
    chk("br_hz_outs", 32'(o1), 32'(6'b111111));
    tick();
    idle();
    chk("br_hz_flush_cnt", 32'(flush_cnt), 1);
    chk("br_hz_stall_cnt", 32'(stall_cnt), 0);

    // Three-cycle memory wait with a pending branch
    do_reset();
    mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mw_br_frozen_%0d", c), 32'(o1), 0);
      if (c > 0) chk($sformatf("mw_br_state_%0d", c), 32'(state), 2);
      tick();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("mw_br_exit_outs", 32'(o1), 32'(6'b111111));
    chk("mw_br_exit_state", 32'(state), 2);
    tick();
    idle();
    chk("mw_br_after_state", 32'(state), 0);
    chk("mw_br_flush_cnt", 32'(flush_cnt), 1);
    chk("mw_br_stall_cnt", 32'(stall_cnt), 3);

    // Three bubbles with a two-cycle memory wait in the second bubble
    do_reset();
    zeros = 0;
    drive_hz();
    @(negedge clk);
    if (!pc_en3) zeros++;
    chk("lu3_s0", 32'(state3), 0);
    tick();
    idle();
    mem_req = 1; mem_ready = 0;
    @(negedge clk);
    if (!pc_en3) zeros++;
    chk("lu3_s1", 32'(state3), 1);
    tick();
    @(negedge clk);
    if (!pc_en3) zeros++;
    chk("lu3_s2", 32'(state3), 2);
    tick();
    mem_ready = 1;
    @(negedge clk);
    if (!pc_en3) zeros++;
    chk("lu3_s3", 32'(state3), 2);
    chk("lu3_exit_outs", 32'(o3), 32'(6'b001101));
    tick();
    idle();
    @(negedge clk);
    if (!pc_en3) zeros++;
    chk("lu3_s4", 32'(state3), 1);
    tick();
    @(negedge clk);
    if (!pc_en3) zeros++;
    chk("lu3_s5", 32'(state3), 0);
    chk("lu3_s5_outs", 32'(o3), 32'(6'b111100));
    chk("lu3_pc_low_cycles", 32'(zeros), 5);
    tick();
    chk("lu3_stall_cnt", 32'(stall_cnt3), 5);

    // Counter saturation on the 4-bit instance
    do_reset();
    drive_hz();
    repeat (20) tick();
    chk("sat_stall_cnt3", 32'(stall_cnt3), 15);
    chk("nosat_stall_cnt16", 32'(stall_cnt), 20);
    repeat (3) tick();
    chk("sat_hold_cnt3", 32'(stall_cnt3), 15);
    idle();

    // Reset while frozen
    do_reset();
    mem_req = 1; mem_ready = 0;
    tick();
    tick();
    chk("rstmw_state", 32'(state), 2);
    chk("rstmw_stall_cnt", 32'(stall_cnt), 2);
    reset = 1;
    @(negedge clk);
    chk("rstmw_outs", 32'(o1), 32'(6'b000011));
    tick();
    reset = 0;
    idle();
    chk("rstmw_after_state", 32'(state), 0);
    chk("rstmw_after_stall", 32'(stall_cnt), 0);
    chk("rstmw_after_flush", 32'(flush_cnt), 0);
    @(negedge clk);
    chk("rstmw_after_outs", 32'(o1), 32'(6'b111100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
